// File: rtl/lcd_write_sched.sv
// lcd_write_sched: round-robin scheduler for two writers sharing the 8-bit
// LCD write port. It latches the winning byte and RS flag, then drives the
// panel strobe through setup, pulse and hold phases.
module lcd_write_sched #(
    parameter int unsigned SETUP_CYC = 2,   // data/RS stable before strobe (1..255)
    parameter int unsigned PULSE_CYC = 4,   // strobe high time (1..255)
    parameter int unsigned HOLD_CYC  = 2    // data/RS stable after strobe (1..255)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_wr,
    output logic       busy
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Phase lengths are loaded as "remaining cycles minus one".
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              last_grant_q;
    logic              last_grant_d;

    logic [DATA_W-1:0] lcd_data_d;
    logic              lcd_rs_d;
    logic              lcd_wr_d;
    logic              ack0_d;
    logic              ack1_d;
    logic              busy_d;

    logic              any_req;
    logic              grant_port;
    logic              cnt_zero;

    // Arbitration: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        any_req    = req0 | req1;
        grant_port = req1 & (~req0 | ~last_grant_q);
        cnt_zero   = (cnt_q == '0);
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        lcd_data_d   = lcd_data;
        lcd_rs_d     = lcd_rs;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_SETUP;
                    cnt_d        = SETUP_LD;
                    last_grant_d = grant_port;
                    lcd_data_d   = grant_port ? data1 : data0;
                    lcd_rs_d     = grant_port ? rs1 : rs0;
                    ack0_d       = ~grant_port;
                    ack1_d       = grant_port;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_STROBE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        lcd_wr_d = (state_d == ST_STROBE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State, phase counter and fairness pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Registered panel and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
            lcd_wr   <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            lcd_data <= lcd_data_d;
            lcd_rs   <= lcd_rs_d;
            lcd_wr   <= lcd_wr_d;
            ack0     <= ack0_d;
            ack1     <= ack1_d;
            busy     <= busy_d;
        end
    end

endmodule
